// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX operand forwarding selects, load-use
// bubble insertion and multi-cycle multiplier sequencing with front-of-pipe freeze.

module hazard_fwd_lane #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_we_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_we_i,
  output logic [1:0]       sel_o
);
  // Younger producer (EX/MEM) wins; r0 is hardwired zero and never forwarded.
  always_comb begin
    sel_o = 2'b00;
    if (mem_we_i && (mem_rd_i == ex_rs_i) && (mem_rd_i != '0))
      sel_o = 2'b10;
    else if (wb_we_i && (wb_rd_i == ex_rs_i) && (wb_rd_i != '0))
      sel_o = 2'b01;
  end
endmodule

module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int MULT_LAT = 3
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] ex_rs1_i,
  input  logic [REG_W-1:0] ex_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_mult_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_reg_write_i,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             idex_hold_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             mult_start_o,
  output logic             mult_done_o
);
  localparam logic [3:0] LAST = 4'(MULT_LAT - 1);

  typedef enum logic {IDLE, MBUSY} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0][REG_W-1:0] ex_rs;
  logic [1:0][1:0]       sel;

  assign ex_rs = {ex_rs2_i, ex_rs1_i};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    hazard_fwd_lane #(.REG_W(REG_W)) u_lane (
      .ex_rs_i  (ex_rs[g]),
      .mem_rd_i (mem_rd_i),
      .mem_we_i (mem_reg_write_i),
      .wb_rd_i  (wb_rd_i),
      .wb_we_i  (wb_reg_write_i),
      .sel_o    (sel[g])
    );
  end

  logic load_use;
  assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  logic pc_hold, ifid_hold, idex_hold, idex_flush, exmem_flush, mstart, mdone;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mstart      = 1'b0;
    mdone       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mult_i) begin
          // Multiply outranks load-use: ID/EX is frozen, so the load-use bubble is moot.
          mstart      = 1'b1;
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_hold   = 1'b1;
          exmem_flush = 1'b1;
          state_d     = MBUSY;
          cnt_d       = 4'd1;
        end else if (load_use) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
        end
      end
      MBUSY: begin
        if (cnt_q < LAST) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_hold   = 1'b1;
          exmem_flush = 1'b1;
          cnt_d       = cnt_q + 4'd1;
        end else begin
          mdone   = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational from live inputs, so they are forced quiet while in reset.
  assign fwd_a_sel_o   = arst_n_i ? sel[0] : 2'b00;
  assign fwd_b_sel_o   = arst_n_i ? sel[1] : 2'b00;
  assign pc_hold_o     = arst_n_i & pc_hold;
  assign ifid_hold_o   = arst_n_i & ifid_hold;
  assign idex_hold_o   = arst_n_i & idex_hold;
  assign idex_flush_o  = arst_n_i & idex_flush;
  assign exmem_flush_o = arst_n_i & exmem_flush;
  assign mult_start_o  = arst_n_i & mstart;
  assign mult_done_o   = arst_n_i & mdone;
endmodule
